// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_e         : converter FSM states
//   BCD_ADJ_THRESH  : digit value at which the shift-and-add-3 correction applies
//   BCD_ADJ_ADD     : correction added to a digit before the shift
//   cnt_width()     : width of a counter able to hold 0..n
package bin2bcd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bin2bcd_seq_adj.sv
// Single-digit double-dabble correction: adds 3 to a BCD digit that is 5 or
// more, so the following left shift carries correctly into the next digit.
//   digit_i : 4-bit BCD digit before the shift
//   digit_o : corrected digit (4-bit modulo; inputs above 9 never occur)
module bcd_digit_adj
    import bin2bcd_seq_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // Conditional +3 correction
    always_comb begin
        if (digit_i >= BCD_ADJ_THRESH) begin
            digit_o = digit_i + BCD_ADJ_ADD;
        end else begin
            digit_o = digit_i;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one bit per clock,
// with valid/ready handshakes on both sides.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : input handshake, bin_in is the operand
//   out_valid / out_ready: output handshake, bcd_out is the packed result
//                          (digit 0 = units in bits [3:0])
//   busy                 : conversion in progress
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  busy
);

    localparam int CNT_W = cnt_width(BIN_W);
    localparam int BCD_W = 4 * DIGITS;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   acc_q, acc_d;
    logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
    logic               out_valid_q, out_valid_d;

    logic [BCD_W-1:0]   adj_s;
    logic [BCD_W-1:0]   shifted_s;
    logic               accept_s;
    logic               xfer_s;
    logic               last_iter_s;

    // Per-digit correction applied to the accumulator before each shift
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (acc_q[4*g +: 4]),
            .digit_o (adj_s[4*g +: 4])
        );
    end

    // The binary MSB enters the BCD LSB as the combined register shifts left
    assign shifted_s   = {adj_s[BCD_W-2:0], bin_q[BIN_W-1]};
    assign accept_s    = in_valid && in_ready;
    assign xfer_s      = out_valid_q && out_ready;
    assign last_iter_s = (cnt_q == LAST_ITER);

    assign out_valid = out_valid_q;
    assign bcd_out   = bcd_out_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bin_q       <= '0;
            acc_q       <= '0;
            bcd_out_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bin_q       <= bin_d;
            acc_q       <= acc_d;
            bcd_out_q   <= bcd_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_iter_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                // A new operand may be loaded on the same edge as the transfer
                if (xfer_s && in_valid) begin
                    state_d = ST_SHIFT;
                end else if (xfer_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake and status outputs decoded from the current state
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_SHIFT: begin
                busy = 1'b1;
            end
            ST_DONE: begin
                // Accept only when the held result leaves on this edge
                in_ready = out_ready;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Datapath next values: operand load, iteration and result capture
    always_comb begin
        cnt_d       = cnt_q;
        bin_d       = bin_q;
        acc_d       = acc_q;
        bcd_out_d   = bcd_out_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    bin_d = bin_in;
                    acc_d = '0;
                    cnt_d = '0;
                end else begin
                    bin_d = bin_q;
                end
            end
            ST_SHIFT: begin
                acc_d = shifted_s;
                bin_d = {bin_q[BIN_W-2:0], 1'b0};
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter_s) begin
                    bcd_out_d   = shifted_s;
                    out_valid_d = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            ST_DONE: begin
                if (xfer_s) begin
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = 1'b1;
                end
                if (accept_s) begin
                    bin_d = bin_in;
                    acc_d = '0;
                    cnt_d = '0;
                end else begin
                    bin_d = bin_q;
                end
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

endmodule
